// File: rtl/pam_pkg.sv
// -----------------------------------------------------------------------------
// pam_pkg
//
// Purpose:
//   Shared definitions for the pipelined array multiplier. Holds the helpers
//   that split the MID partial-product rows across the pipeline stages.
//   Every stage gets R = ceil(MID/STAGES) rows, and the last stage takes the
//   remainder. When STAGES does not divide MID evenly, trailing stages can
//   hold zero rows and simply carry the payload forward.
//
//   The stage payload struct {sign, tag, a_ext, b_ext, psum, carry} is
//   parameter-width dependent. For that reason it is declared inside the top
//   module, next to the MUL_SIZE/TAG_W parameters that size it.
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package pam_pkg;

   // Default operand width, mirrored by the top-level parameter default.
   localparam int DEF_MUL_SIZE = 4;

   // Width of the extended operands and of the full product.
   function automatic int mid_width(input int mul_size);
      return 2 * mul_size;
   endfunction

   // Nominal rows per stage: ceil(mid / stages).
   function automatic int rows_per_stage(input int mid, input int stages);
      return (mid + stages - 1) / stages;
   endfunction

   // Number of partial-product rows evaluated in a given stage.
   function automatic int rows_in_stage(input int stage, input int mid,
                                        input int stages);
      int r;
      int first;
      r     = rows_per_stage(mid, stages);
      first = stage * r;
      if (first >= mid) begin
         return 0;
      end
      if (mid - first < r) begin
         return mid - first;
      end
      return r;
   endfunction

   // Index of the first row handled by a stage. The index is clamped into
   // range so that empty stages never form an out-of-range bit select.
   function automatic int first_row(input int stage, input int mid,
                                    input int stages);
      int first;
      first = stage * rows_per_stage(mid, stages);
      if (first > mid - 1) begin
         return mid - 1;
      end
      return first;
   endfunction

endpackage : pam_pkg

// File: rtl/pam_row_stage.sv
// -----------------------------------------------------------------------------
// pam_row_stage
//
// Purpose:
//   A combinational group of NUM_ROWS partial-product rows, starting at row
//   FIRST_ROW. Each row is a mul_slice carry-save step. It adds (b_ext[row] ?
//   a_ext << row : 0) into the redundant (psum, carry) pair without
//   propagating carries. The pair always satisfies the following invariant:
//   psum + carry == running product, taken mod 2^MID.
//
// Ports:
//   a_ext      in  MID  extended multiplicand
//   b_ext      in  MID  extended multiplier (one bit selects each row)
//   psum_in    in  MID  incoming partial sum
//   carry_in   in  MID  incoming carry vector (already weight-aligned)
//   psum_out   out MID  partial sum after this group's rows
//   carry_out  out MID  carry vector after this group's rows
// -----------------------------------------------------------------------------
module pam_row_stage #(
   parameter int MID       = 8,
   parameter int FIRST_ROW = 0,
   parameter int NUM_ROWS  = 4
) (
   input  logic [MID-1:0] a_ext,
   input  logic [MID-1:0] b_ext,
   input  logic [MID-1:0] psum_in,
   input  logic [MID-1:0] carry_in,
   output logic [MID-1:0] psum_out,
   output logic [MID-1:0] carry_out
);

   logic [MID-1:0] s_v;
   logic [MID-1:0] c_v;
   logic [MID-1:0] pp_v;
   logic [MID-1:0] ns_v;
   logic [MID-1:0] nc_v;

   // Only some b_ext bits select rows here, and high a_ext bits shift out.
   // Both are consumed elsewhere along the chain.
   logic unused_operand_bits;
   assign unused_operand_bits = ^{a_ext, b_ext};

   always_comb begin
      s_v  = psum_in;
      c_v  = carry_in;
      pp_v = '0;
      ns_v = '0;
      nc_v = '0;
      for (int k = 0; k < NUM_ROWS; k++) begin
         pp_v = b_ext[FIRST_ROW + k] ? (a_ext << (FIRST_ROW + k)) : '0;
         // 3:2 compression. The carry out of bit MID-1 has weight 2^MID and
         // is dropped, because the result is defined modulo 2^MID.
         ns_v = s_v ^ c_v ^ pp_v;
         nc_v = ((s_v & c_v) | (s_v & pp_v) | (c_v & pp_v)) << 1;
         s_v  = ns_v;
         c_v  = nc_v;
      end
      psum_out  = s_v;
      carry_out = c_v;
   end

endmodule : pam_row_stage

// File: rtl/pipelined_array_multiplier.sv
// -----------------------------------------------------------------------------
// pipelined_array_multiplier
//
// Purpose:
//   Computes the full 2*MUL_SIZE-bit product of two MUL_SIZE-bit operands.
//   Signed or unsigned mode is selected per beat. Operands are extended to
//   MID = 2*MUL_SIZE bits (sign- or zero-extended). The MID x MID array is
//   then truncated to MID bits, which is exact for both modes.
//
//   The MID partial-product rows are spread across STAGES register stages.
//   Each stage carries a redundant (psum, carry) pair. The last stage
//   resolves that pair with a single carry-propagate add before its
//   register, so m_out comes straight from a flop.
//
//   Flow control uses one global enable. When the output holds a product
//   that downstream refuses (m_valid && !m_ready), the whole pipe freezes,
//   valid bits included. Otherwise every stage shifts forward by one step
//   and a bubble enters when in_valid is low.
//
//   Valid/ready contract (both interfaces): a beat transfers on a rising
//   edge where valid and ready are both high. The source keeps valid and
//   its payload stable until that edge. The sink's ready may depend
//   combinationally on its own registered state and on the downstream ready.
//
//   A stage's payload loads only when a valid beat enters it. A bubble
//   therefore leaves the old payload in place, and m_out/tag_out keep their
//   last value while m_valid is low.
//
// Ports:
//   clk       in   1           rising-edge clock
//   rst       in   1           asynchronous active-high reset
//   in_valid  in   1           operand beat valid
//   in_ready  out  1           beat can be accepted this cycle
//   sign      in   1           1 = two's complement operands, 0 = unsigned
//   a_in      in   MUL_SIZE    multiplicand
//   b_in      in   MUL_SIZE    multiplier
//   tag_in    in   TAG_W       user tag, returned with the product
//   m_valid   out  1           product valid
//   m_ready   in   1           downstream accepts the product
//   m_out     out  2*MUL_SIZE  product
//   tag_out   out  TAG_W       tag belonging to m_out
// -----------------------------------------------------------------------------
module pipelined_array_multiplier
   import pam_pkg::*;
#(
   parameter int MUL_SIZE = DEF_MUL_SIZE,
   parameter int STAGES   = 2,
   parameter int TAG_W    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    sign,
   input  logic [MUL_SIZE-1:0]     a_in,
   input  logic [MUL_SIZE-1:0]     b_in,
   input  logic [TAG_W-1:0]        tag_in,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [2*MUL_SIZE-1:0]   m_out,
   output logic [TAG_W-1:0]        tag_out
);

   localparam int MID = mid_width(MUL_SIZE);

   // Payload held by every stage register.
   typedef struct packed {
      logic             sign;
      logic [TAG_W-1:0] tag;
      logic [MID-1:0]   a_ext;
      logic [MID-1:0]   b_ext;
      logic [MID-1:0]   psum;
      logic [MID-1:0]   carry;
   } stage_t;

   stage_t            stg_q   [STAGES];
   stage_t            stg_d   [STAGES];
   stage_t            stg_in  [STAGES];
   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] vld_d;
   logic [STAGES-1:0] vld_in;
   logic [MID-1:0]    psum_nx [STAGES];
   logic [MID-1:0]    carry_nx[STAGES];
   logic              stall;
   logic              adv;

   // ---------------------------------------------------------------------
   // Stage inputs: stage 0 takes the extended operands from the ports,
   // and every later stage takes the register of the stage before it.
   // ---------------------------------------------------------------------
   always_comb begin
      stg_in[0].sign  = sign;
      stg_in[0].tag   = tag_in;
      stg_in[0].a_ext = sign ? {{MUL_SIZE{a_in[MUL_SIZE-1]}}, a_in}
                             : {{MUL_SIZE{1'b0}}, a_in};
      stg_in[0].b_ext = sign ? {{MUL_SIZE{b_in[MUL_SIZE-1]}}, b_in}
                             : {{MUL_SIZE{1'b0}}, b_in};
      stg_in[0].psum  = '0;
      stg_in[0].carry = '0;
      vld_in[0]       = in_valid;
      for (int s = 1; s < STAGES; s++) begin
         stg_in[s] = stg_q[s-1];
         vld_in[s] = vld_q[s-1];
      end
   end

   // ---------------------------------------------------------------------
   // Row groups, one per stage
   // ---------------------------------------------------------------------
   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      pam_row_stage #(
         .MID       (MID),
         .FIRST_ROW (first_row(g, MID, STAGES)),
         .NUM_ROWS  (rows_in_stage(g, MID, STAGES))
      ) u_rows (
         .a_ext     (stg_in[g].a_ext),
         .b_ext     (stg_in[g].b_ext),
         .psum_in   (stg_in[g].psum),
         .carry_in  (stg_in[g].carry),
         .psum_out  (psum_nx[g]),
         .carry_out (carry_nx[g])
      );
   end

   // ---------------------------------------------------------------------
   // Global enable and next-state for the stage chain
   // ---------------------------------------------------------------------
   always_comb begin
      stall = vld_q[STAGES-1] & ~m_ready;
      adv   = ~stall;
      vld_d = vld_q;
      for (int s = 0; s < STAGES; s++) begin
         stg_d[s] = stg_q[s];
         if (adv) begin
            vld_d[s] = vld_in[s];
            if (vld_in[s]) begin
               stg_d[s]       = stg_in[s];
               stg_d[s].psum  = psum_nx[s];
               stg_d[s].carry = carry_nx[s];
               if (s == STAGES - 1) begin
                  // Resolve the redundant pair so the output flop holds
                  // the finished product.
                  stg_d[s].psum  = psum_nx[s] + carry_nx[s];
                  stg_d[s].carry = '0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int s = 0; s < STAGES; s++) begin
            stg_q[s] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int s = 0; s < STAGES; s++) begin
            stg_q[s] <= stg_d[s];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign in_ready = adv;
   assign m_valid  = vld_q[STAGES-1];
   assign m_out    = stg_q[STAGES-1].psum;
   assign tag_out  = stg_q[STAGES-1].tag;

   // The sign bit travels with each beat for observability. Its effect is
   // already folded into the extended operands. The operands and the
   // cleared carry of the final stage are not needed past the output flop.
   logic unused_stage_bits;
   always_comb begin
      unused_stage_bits = ^{stg_q[STAGES-1].a_ext, stg_q[STAGES-1].b_ext,
                            stg_q[STAGES-1].carry};
      for (int s = 0; s < STAGES; s++) begin
         unused_stage_bits = unused_stage_bits ^ stg_q[s].sign;
      end
   end

endmodule : pipelined_array_multiplier

// File: doc/pipelined_array_multiplier.md
Name: pipelined_array_multiplier

Overview:
- Pipelined, parametrised successor to the combinational array multiplier.
- Computes the full 2*MUL_SIZE-bit product of two MUL_SIZE-bit operands, per-transaction signed/unsigned mode.
- Partial-product rows are split into STAGES register-separated groups; one result per cycle with valid/ready flow control and a pass-through user tag.
- Sits between operand producers (DSP datapath, MAC units) and downstream accumulators.

Parameters:
- MUL_SIZE, 4, operand width in bits (>=2).
- STAGES, 2, pipeline depth in register stages (1..2*MUL_SIZE); also the latency.
- TAG_W, 4, width of user tag carried alongside each product (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- sign  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the beat.
- a_in  input  MUL_SIZE  multiplicand.
- b_in  input  MUL_SIZE  multiplier.
- tag_in  input  TAG_W  user tag, returned unchanged with the product.
- m_valid  output  1  product valid.
- m_ready  input  1  downstream accepts product.
- m_out  output  2*MUL_SIZE  product.
- tag_out  output  TAG_W  tag of the beat producing m_out.

Behaviour:
- Reset (async assert, sync release): every stage valid bit = 0, m_valid = 0, m_out = 0, tag_out = 0. in_ready = 1 from the first edge after release.
- Operand extension: sign=1 sign-extends to MID = 2*MUL_SIZE bits; sign=0 zero-extends. The product is the low 2*MUL_SIZE bits of the MID x MID array result, so it is exact for both modes.
- Row partition: MID partial-product rows. Each stage holds R = ceil(MID/STAGES) rows; the last stage holds the remainder.
- Per-stage registers: stage valid bit, sign, tag, running partial-sum/carry vectors, and extended a/b operands needed by later rows. Settled low product bits propagate forward.
- Handshake: accept a beat on the edge where in_valid && in_ready. Deliver a beat on the edge where m_valid && m_ready.
- Stall rule (global enable): stall = m_valid && !m_ready. in_ready = !stall.
  - When stall is true, all stage registers hold, including valid bits.
  - When stall is false, every stage shifts forward one step. A bubble enters stage 1 when in_valid=0.
- Latency: an accepted beat appears on m_valid/m_out/tag_out exactly STAGES edges later, absent stalls. Each stall cycle adds exactly one cycle.
- Throughput: 1 beat/cycle with m_ready held high. No beat is lost or duplicated under any m_ready pattern.
- Ordering: strictly in-order. tag_out always pairs with its own product.
- Outputs are registered: m_out/tag_out are the last-stage registers, and hold their value while m_valid=0 (no X).
- Simultaneous events: when the output is delivered and a new input is accepted on the same edge, both complete with no bubble.
- Boundary operand values must be exact:
  - Most-negative signed operand (-2^(MUL_SIZE-1)).
  - All-ones unsigned operand.
  - Zero operands.
- Reset mid-operation: all in-flight beats are discarded and m_valid drops immediately (async). No partial result is emitted after release.
- STAGES=1: fully combinational array followed by a single output register; latency 1.

Decomposition:
- Shared package pam_pkg:
  - Localparam MID = 2*MUL_SIZE.
  - Function rows_in_stage(stage) for the partition.
  - Typedef of the stage payload struct {sign, tag, a_ext, b_ext, psum, carry}.
- One natural sub-module: pam_row_stage. It is a combinational group of R rows built from the existing mul_slice carry-save cell. The top module instantiates STAGES copies plus the enable/valid register chain.

Test Plan:
- Unsigned, MUL_SIZE=4, STAGES=2: a=15, b=15, sign=0, tag=3 -> after 2 cycles m_valid=1, m_out=8'hE1 (225), tag_out=3.
- Signed corners: (-8)*7 -> 8'hC8; (-8)*(-8) -> 8'h40; (-1)*(-1) -> 8'h01; 0*(-5) -> 8'h00. Issue back-to-back with m_ready=1 -> four results on consecutive cycles, in order, tags intact.
- Backpressure: stream 10 random beats while m_ready toggles in the pattern 1,0,0,1,0,... -> in_ready = !(m_valid && !m_ready) every cycle; all 10 products match the reference model, in order, with no duplicate or drop.
- Mixed mode: alternate sign=1/0 with a=4'b1000, b=4'b0010 -> 8'hF0 (-16) and 8'h10 (16) respectively.
- Reset mid-flight: accept 2 beats, assert rst before the first emerges -> m_valid=0 at once, outputs 0. After release, one new beat 3*5 -> only 8'h0F emitted, after 2 cycles.
- Parameter sweep: MUL_SIZE in {4,8}, STAGES in {1,3,2*MUL_SIZE} -> exhaustive (4-bit) or 10k random (8-bit) checks against the behavioural product; latency = STAGES.
